// File: rtl/attack_coprocessor.sv
// Attack state machine for one fighter: startup/active/recovery phases, hit detection, damage and knockback.
// Define ATTACK_DAMAGE_SCALING_EN to scale knockback with accumulated damage; otherwise knockback is BASE_KB.
module attack_coprocessor #(
    parameter int TICK_BITS      = 12,
    parameter int STARTUP_TICKS  = 4,
    parameter int ACTIVE_TICKS   = 3,
    parameter int RECOVERY_TICKS = 6,
    parameter int RANGE_X        = 24,
    parameter int RANGE_Y        = 16,
    parameter int BASE_KB        = 64,
    parameter int DMG_PER_HIT    = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] controller_in,
    input  logic [31:0] own_position,
    input  logic [31:0] opp_position,
    input  logic        damage_clear,
    output logic        attack_out,
    output logic [31:0] knockback_out,
    output logic        hit_pulse,
    output logic [9:0]  damage_out
);

    localparam int PH_W = 8;

    typedef enum logic [1:0] {IDLE, STARTUP, ACTIVE, RECOVERY} state_t;

    function automatic logic [9:0] sat_damage(input logic [9:0] d);
        logic [10:0] s;
        s = {1'b0, d} + 11'(DMG_PER_HIT);
        return (s > 11'd999) ? 10'd999 : s[9:0];
    endfunction

    function automatic logic [16:0] abs17(input logic signed [16:0] v);
        return v[16] ? 17'(-v) : 17'(v);
    endfunction

`ifdef ATTACK_DAMAGE_SCALING_EN
    function automatic logic [15:0] kb_magnitude(input logic [9:0] d);
        logic [17:0] m;
        m = 18'(BASE_KB) + {6'd0, d, 2'b00};
        return (m > 18'h7FFF) ? 16'h7FFF : m[15:0];
    endfunction
`endif

    logic [TICK_BITS-1:0] prescaler;
    logic                 tick;
    state_t               state;
    logic [PH_W-1:0]      phase;
    logic                 hit_done;
    logic                 facing_right;
    logic                 btn_prev;
    logic                 press;
    logic                 phase_end;

    logic signed [16:0]   dx_p0;
    logic signed [16:0]   dy_p0;
    logic                 in_range_p0;
    logic                 dir_ok_p0;
    logic                 vld_p0;
    logic [9:0]           dmg_next_p0;
    logic signed [15:0]   mag_p0;
    logic                 unused_ctrl;

    assign unused_ctrl = ^{controller_in[31:26], controller_in[24:16], controller_in[7:0]};

    // Tick is registered so it lands in the cycle where the prescaler reads zero after wrapping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prescaler <= '0;
            tick      <= 1'b0;
        end else begin
            prescaler <= prescaler + 1'b1;
            tick      <= &prescaler;
        end
    end

    assign press     = controller_in[25] & ~btn_prev;
    assign phase_end = (phase <= PH_W'(1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            phase        <= '0;
            hit_done     <= 1'b0;
            facing_right <= 1'b1;
            btn_prev     <= 1'b0;
        end else begin
            btn_prev <= controller_in[25];
            if (vld_p0)
                hit_done <= 1'b1;
            case (state)
                IDLE: if (press) begin
                    state        <= STARTUP;
                    phase        <= PH_W'(STARTUP_TICKS);
                    facing_right <= controller_in[15];
                    hit_done     <= 1'b0;
                end
                STARTUP: if (tick) begin
                    if (phase_end) begin
                        state <= ACTIVE;
                        phase <= PH_W'(ACTIVE_TICKS);
                    end else
                        phase <= phase - 1'b1;
                end
                ACTIVE: if (tick) begin
                    if (phase_end) begin
                        state <= RECOVERY;
                        phase <= PH_W'(RECOVERY_TICKS);
                    end else
                        phase <= phase - 1'b1;
                end
                RECOVERY: if (tick) begin
                    if (phase_end) begin
                        state <= IDLE;
                        phase <= '0;
                    end else
                        phase <= phase - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign attack_out = (state != IDLE);

    // Stage p0: hit test against the opponent and next damage/knockback values.
    assign dx_p0       = $signed({1'b0, opp_position[31:16]}) - $signed({1'b0, own_position[31:16]});
    assign dy_p0       = $signed({1'b0, opp_position[15:0]})  - $signed({1'b0, own_position[15:0]});
    assign in_range_p0 = (abs17(dx_p0) <= 17'(RANGE_X)) && (abs17(dy_p0) <= 17'(RANGE_Y));
    assign dir_ok_p0   = facing_right ? ~dx_p0[16] : (dx_p0[16] || (dx_p0 == 17'sd0));
    assign vld_p0      = (state == ACTIVE) && !hit_done && in_range_p0 && dir_ok_p0;
    assign dmg_next_p0 = sat_damage(damage_out);

`ifdef ATTACK_DAMAGE_SCALING_EN
    logic [9:0] dmg_kb_p0;
    // A clear in the hit cycle means the knockback sees a fresh stock.
    assign dmg_kb_p0 = damage_clear ? 10'd0 : dmg_next_p0;
    assign mag_p0    = $signed(kb_magnitude(dmg_kb_p0));
`else
    assign mag_p0    = $signed(16'(BASE_KB));
`endif

    // Stage p1: registered hit outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hit_pulse     <= 1'b0;
            damage_out    <= '0;
            knockback_out <= '0;
        end else begin
            hit_pulse <= vld_p0;
            if (damage_clear)
                damage_out <= '0;
            else if (vld_p0)
                damage_out <= dmg_next_p0;
            if (vld_p0)
                knockback_out <= {(facing_right ? mag_p0 : -mag_p0), {1'b0, mag_p0[15:1]}};
        end
    end

endmodule

// File: tb/tb_attack_coprocessor.sv
// Scoreboard bench for attack_coprocessor with a fast prescaler; expectations follow ATTACK_DAMAGE_SCALING_EN.
module tb_attack_coprocessor;

`ifdef ATTACK_DAMAGE_SCALING_EN
    localparam bit SCALE = 1'b1;
`else
    localparam bit SCALE = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] controller_in = '0;
    logic [31:0] own_position  = '0;
    logic [31:0] opp_position  = '0;
    logic        damage_clear  = 1'b0;
    logic        attack_out;
    logic [31:0] knockback_out;
    logic        hit_pulse;
    logic [9:0]  damage_out;

    typedef struct {
        logic [9:0]  dmg;
        logic [31:0] kb;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    attack_coprocessor #(.TICK_BITS(2)) dut (
        .clock(clock),
        .reset(reset),
        .controller_in(controller_in),
        .own_position(own_position),
        .opp_position(opp_position),
        .damage_clear(damage_clear),
        .attack_out(attack_out),
        .knockback_out(knockback_out),
        .hit_pulse(hit_pulse),
        .damage_out(damage_out)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic int mag(input int d);
        int m;
        if (!SCALE) return 64;
        m = 64 + 4 * d;
        return (m > 32767) ? 32767 : m;
    endfunction

    task automatic expect_hit(input int d, input bit right);
        exp_t e;
        logic [15:0] x;
        x = right ? 16'(mag(d)) : 16'(-mag(d));
        e.dmg = 10'(d);
        e.kb  = {x, 16'(mag(d) >> 1)};
        exp_q.push_back(e);
    endtask

    // Monitor: every hit_pulse cycle must match the oldest expected hit.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset && hit_pulse) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_hit: hit_pulse 1 with dmg %0d, required no hit", damage_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("hit_damage", 32'(damage_out), 32'(e.dmg));
                    chk("hit_knockback", knockback_out, e.kb);
                end
            end
        end
    end

    task automatic set_pos(input int ox, input int oy, input int px, input int py, input int joy);
        own_position          = {16'(ox), 16'(oy)};
        opp_position          = {16'(px), 16'(py)};
        controller_in[15:8]   = 8'(joy);
    endtask

    // One press; measures clocks from attack_out rising to falling, optionally re-pressing mid-attack.
    task automatic attack(input int press_again_at);
        int dur;
        @(posedge clock); #1 controller_in[25] = 1'b1;
        @(posedge clock); #1 controller_in[25] = 1'b0;
        chk("attack_rise", 32'(attack_out), 32'd1);
        dur = 0;
        while (attack_out && dur < 200) begin
            @(posedge clock); #1;
            dur++;
            if (dur == press_again_at) controller_in[25] = 1'b1;
            else if (dur == press_again_at + 1) controller_in[25] = 1'b0;
        end
        n_cmp++;
        if (dur < 49 || dur > 52) begin
            n_bad++;
            $display("FAIL attack_duration: got %0d clocks, required 49..52", dur);
        end
    endtask

    initial begin
        int rises;
        int hi_cnt;
        int k;
        int d;
        bit prev;
        bit found;

        // Reset state
        #12;
        chk("rst_attack", 32'(attack_out), 32'd0);
        chk("rst_kb", knockback_out, 32'd0);
        chk("rst_pulse", 32'(hit_pulse), 32'd0);
        chk("rst_damage", 32'(damage_out), 32'd0);
        @(posedge clock); #1 reset = 1'b1;
        repeat (3) @(posedge clock);

        // Facing right, opponent 20px ahead
        set_pos(100, 50, 120, 50, 200);
        expect_hit(8, 1'b1);
        attack(0);
        // Facing left with opponent ahead-right: no hit; then opponent behind-left hits
        set_pos(100, 50, 120, 50, 50);
        attack(0);
        set_pos(100, 50, 80, 50, 50);
        expect_hit(16, 1'b0);
        attack(0);
        // Range boundaries
        set_pos(100, 50, 124, 66, 200);
        expect_hit(24, 1'b1);
        attack(0);
        set_pos(100, 50, 125, 50, 200);
        attack(0);
        set_pos(100, 50, 120, 67, 200);
        attack(0);
        set_pos(100, 50, 90, 50, 200);
        attack(0);
        chk("damage_after_range", 32'(damage_out), 32'd24);

        // Held button: exactly one attack
        set_pos(100, 50, 300, 50, 200);
        @(posedge clock); #1 controller_in[25] = 1'b1;
        rises = 0;
        prev  = 1'b0;
        for (int i = 0; i < 160; i++) begin
            @(posedge clock); #1;
            if (attack_out && !prev) rises++;
            prev = attack_out;
        end
        controller_in[25] = 1'b0;
        chk("held_one_attack", 32'(rises), 32'd1);
        chk("held_idle", 32'(attack_out), 32'd0);

        // Press during recovery is ignored
        attack(32);
        hi_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1;
            if (attack_out) hi_cnt++;
        end
        chk("recovery_press_ignored", 32'(hi_cnt), 32'd0);

        // Clear, then accumulate up to saturation
        @(posedge clock); #1 damage_clear = 1'b1;
        @(posedge clock); #1 damage_clear = 1'b0;
        chk("damage_cleared", 32'(damage_out), 32'd0);
        set_pos(100, 50, 120, 50, 200);
        for (k = 1; k <= 126; k++) begin
            d = (8 * k > 999) ? 999 : 8 * k;
            expect_hit(d, 1'b1);
            attack(0);
        end
        chk("damage_saturated", 32'(damage_out), 32'd999);

        // Clear held through the hit cycle
        damage_clear = 1'b1;
        expect_hit(0, 1'b1);
        attack(0);
        damage_clear = 1'b0;
        chk("damage_clear_priority", 32'(damage_out), 32'd0);

        // Reset during ACTIVE
        expect_hit(8, 1'b1);
        @(posedge clock); #1 controller_in[25] = 1'b1;
        @(posedge clock); #1 controller_in[25] = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clock);
            if (hit_pulse) found = 1'b1;
        end
        chk("active_hit_seen", 32'(found), 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("midrst_attack", 32'(attack_out), 32'd0);
        chk("midrst_pulse", 32'(hit_pulse), 32'd0);
        chk("midrst_kb", knockback_out, 32'd0);
        chk("midrst_damage", 32'(damage_out), 32'd0);
        @(posedge clock); #1 reset = 1'b1;

        // Reset during STARTUP with opponent in range: attack aborted, no hit
        @(posedge clock); #1 controller_in[25] = 1'b1;
        @(posedge clock); #1 controller_in[25] = 1'b0;
        repeat (5) @(posedge clock);
        #1 reset = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        hi_cnt = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clock); #1;
            if (attack_out) hi_cnt++;
        end
        chk("abort_no_attack", 32'(hi_cnt), 32'd0);
        chk("abort_damage", 32'(damage_out), 32'd0);

        repeat (5) @(posedge clock);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
